// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: shared state and owner types for the memory port arbiter
`ifndef CPU_WIDTH
`define CPU_WIDTH 64
`endif
package mem_arb_pkg;
  typedef enum logic [2:0] {IDLE, IF_REQ, IF_RESP, LS_REQ, LS_RESP} arb_state_e;
  typedef enum logic {OWN_IF, OWN_LS} arb_owner_e;
endpackage

// File: rtl/mem_arb.sv
// mem_arb: serialises IFU and LSU onto one memory port, LSU priority with an IFU starvation guard
module mem_arb
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W     = `CPU_WIDTH,
  parameter int DATA_W     = `CPU_WIDTH,
  parameter int STARVE_MAX = 4
) (
  input  logic                i_clk,
  input  logic                i_rst_n,
  input  logic                i_if_req,
  input  logic [ADDR_W-1:0]   i_if_addr,
  output logic                o_if_gnt,
  output logic                o_if_rvalid,
  output logic [DATA_W-1:0]   o_if_rdata,
  input  logic                i_ls_req,
  input  logic                i_ls_wen,
  input  logic [ADDR_W-1:0]   i_ls_addr,
  input  logic [DATA_W-1:0]   i_ls_wdata,
  input  logic [DATA_W/8-1:0] i_ls_wmask,
  output logic                o_ls_gnt,
  output logic                o_ls_rvalid,
  output logic [DATA_W-1:0]   o_ls_rdata,
  output logic                o_mem_req,
  output logic                o_mem_wen,
  output logic [ADDR_W-1:0]   o_mem_addr,
  output logic [DATA_W-1:0]   o_mem_wdata,
  output logic [DATA_W/8-1:0] o_mem_wmask,
  input  logic                i_mem_ready,
  input  logic                i_mem_rvalid,
  input  logic [DATA_W-1:0]   i_mem_rdata,
  output logic                o_busy
);
  localparam int CW = $clog2(STARVE_MAX + 1);
  localparam logic [CW-1:0] SMAX = CW'(STARVE_MAX);
  arb_state_e state_q, state_d;
  arb_owner_e owner;
  logic [CW-1:0] cnt_q, cnt_d;
  logic in_req, in_resp, ls_req_st, gnt, rv;
  always_comb begin
    owner       = (state_q == LS_REQ || state_q == LS_RESP) ? OWN_LS : OWN_IF;
    in_req      = state_q == IF_REQ || state_q == LS_REQ;
    in_resp     = state_q == IF_RESP || state_q == LS_RESP;
    ls_req_st   = state_q == LS_REQ;
    gnt         = in_req && i_mem_ready;
    rv          = in_resp && i_mem_rvalid;
    o_if_gnt    = gnt && owner == OWN_IF;
    o_ls_gnt    = gnt && owner == OWN_LS;
    o_if_rvalid = rv && owner == OWN_IF;
    o_ls_rvalid = rv && owner == OWN_LS;
    o_if_rdata  = o_if_rvalid ? i_mem_rdata : '0;
    o_ls_rdata  = o_ls_rvalid ? i_mem_rdata : '0;
    o_mem_req   = in_req;
    o_mem_wen   = ls_req_st && i_ls_wen;
    o_mem_addr  = !in_req ? '0 : owner == OWN_LS ? i_ls_addr : i_if_addr;
    o_mem_wdata = ls_req_st ? i_ls_wdata : '0;
    o_mem_wmask = ls_req_st ? i_ls_wmask : '0;
    o_busy      = state_q != IDLE;
  end
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    state_d = (i_ls_req && !(i_if_req && cnt_q == SMAX)) ? LS_REQ : i_if_req ? IF_REQ : IDLE;
      IF_REQ:  state_d = i_mem_ready ? IF_RESP : IF_REQ;
      IF_RESP: state_d = i_mem_rvalid ? IDLE : IF_RESP;
      LS_REQ:  state_d = i_mem_ready ? LS_RESP : LS_REQ;
      LS_RESP: state_d = i_mem_rvalid ? IDLE : LS_RESP;
      default: state_d = IDLE;
    endcase
    cnt_d = o_if_gnt ? '0 : !o_ls_gnt ? cnt_q : !i_if_req ? '0 : cnt_q == SMAX ? cnt_q : cnt_q + CW'(1);
  end
  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
endmodule

// File: tb/tb_mem_arb.sv
// tb_mem_arb: directed and randomized checks of mem_arb against a transaction-level model
module tb_mem_arb;
  localparam int SM = 4;
  logic clk = 1'b0;
  logic i_rst_n = 1'b0;
  logic i_if_req = 1'b0, i_ls_req = 1'b0, i_ls_wen = 1'b0;
  logic [63:0] i_if_addr = '0, i_ls_addr = '0, i_ls_wdata = '0, i_mem_rdata = '0;
  logic [7:0] i_ls_wmask = '0;
  logic i_mem_ready = 1'b0, i_mem_rvalid = 1'b0;
  logic o_if_gnt, o_if_rvalid, o_ls_gnt, o_ls_rvalid, o_mem_req, o_mem_wen, o_busy;
  logic [63:0] o_if_rdata, o_ls_rdata, o_mem_addr, o_mem_wdata;
  logic [7:0] o_mem_wmask;
  int ncmp = 0, nerr = 0;
  always #5 clk = ~clk;
  mem_arb #(.ADDR_W(64), .DATA_W(64), .STARVE_MAX(SM)) dut (
    .i_clk(clk), .i_rst_n(i_rst_n),
    .i_if_req(i_if_req), .i_if_addr(i_if_addr), .o_if_gnt(o_if_gnt),
    .o_if_rvalid(o_if_rvalid), .o_if_rdata(o_if_rdata),
    .i_ls_req(i_ls_req), .i_ls_wen(i_ls_wen), .i_ls_addr(i_ls_addr),
    .i_ls_wdata(i_ls_wdata), .i_ls_wmask(i_ls_wmask), .o_ls_gnt(o_ls_gnt),
    .o_ls_rvalid(o_ls_rvalid), .o_ls_rdata(o_ls_rdata),
    .o_mem_req(o_mem_req), .o_mem_wen(o_mem_wen), .o_mem_addr(o_mem_addr),
    .o_mem_wdata(o_mem_wdata), .o_mem_wmask(o_mem_wmask),
    .i_mem_ready(i_mem_ready), .i_mem_rvalid(i_mem_rvalid), .i_mem_rdata(i_mem_rdata),
    .o_busy(o_busy)
  );
  a_if_hold: assert property (@(posedge clk) disable iff (!i_rst_n) i_if_req && !o_if_gnt |=> i_if_req)
    else $error("protocol: IFU dropped request before grant");
  a_ls_hold: assert property (@(posedge clk) disable iff (!i_rst_n) i_ls_req && !o_ls_gnt |=> i_ls_req)
    else $error("protocol: LSU dropped request before grant");
  task automatic cmp(input string n, input logic [63:0] a, input logic [63:0] e);
    ncmp++;
    if (a !== e) begin
      nerr++;
      $display("FAIL %s: got %h want %h at %0t", n, a, e, $time);
    end
  endtask
  // transaction-level reference: who owns the port, whether memory has accepted, LSU win streak
  initial begin
    int cur, streak;
    bit acc;
    logic e_req, e_wen, e_ifg, e_lsg, e_ifv, e_lsv, e_busy;
    logic [63:0] e_addr, e_wdata, e_ifd, e_lsd;
    logic [7:0] e_wmask;
    cur = 0; streak = 0; acc = 0;
    forever begin
      @(negedge clk);
      {e_req, e_wen, e_ifg, e_lsg, e_ifv, e_lsv, e_busy} = '0;
      {e_addr, e_wdata, e_ifd, e_lsd, e_wmask} = '0;
      if (!i_rst_n) begin
        cur = 0; streak = 0; acc = 0;
      end else begin
        e_busy = cur != 0;
        if (cur == 0) begin
          if (i_ls_req && !(i_if_req && streak == SM)) cur = 2;
          else if (i_if_req) cur = 1;
        end else if (!acc) begin
          e_req   = 1'b1;
          e_addr  = cur == 2 ? i_ls_addr : i_if_addr;
          e_wen   = cur == 2 && i_ls_wen;
          e_wdata = cur == 2 ? i_ls_wdata : 64'h0;
          e_wmask = cur == 2 ? i_ls_wmask : 8'h0;
          if (i_mem_ready) begin
            acc = 1;
            if (cur == 1) begin
              e_ifg = 1'b1; streak = 0;
            end else begin
              e_lsg = 1'b1; streak = i_if_req ? (streak < SM ? streak + 1 : SM) : 0;
            end
          end
        end else if (i_mem_rvalid) begin
          if (cur == 1) begin e_ifv = 1'b1; e_ifd = i_mem_rdata; end
          else begin e_lsv = 1'b1; e_lsd = i_mem_rdata; end
          cur = 0; acc = 0;
        end
      end
      cmp("m_busy", 64'(o_busy), 64'(e_busy));
      cmp("m_mem_req", 64'(o_mem_req), 64'(e_req));
      cmp("m_mem_wen", 64'(o_mem_wen), 64'(e_wen));
      cmp("m_mem_addr", o_mem_addr, e_addr);
      cmp("m_mem_wdata", o_mem_wdata, e_wdata);
      cmp("m_mem_wmask", 64'(o_mem_wmask), 64'(e_wmask));
      cmp("m_if_gnt", 64'(o_if_gnt), 64'(e_ifg));
      cmp("m_ls_gnt", 64'(o_ls_gnt), 64'(e_lsg));
      cmp("m_if_rvalid", 64'(o_if_rvalid), 64'(e_ifv));
      cmp("m_ls_rvalid", 64'(o_ls_rvalid), 64'(e_lsv));
      cmp("m_if_rdata", o_if_rdata, e_ifd);
      cmp("m_ls_rdata", o_ls_rdata, e_lsd);
    end
  end
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic drain();
    bit gi, gl, done;
    done = 0;
    i_mem_ready = 1'b1; i_mem_rvalid = 1'b1;
    for (int k = 0; k < 40 && !done; k++) begin
      @(negedge clk);
      gi = o_if_gnt; gl = o_ls_gnt;
      done = !i_if_req && !i_ls_req && !o_busy;
      step();
      if (gi) i_if_req = 1'b0;
      if (gl) i_ls_req = 1'b0;
    end
    cmp("drain_done", 64'(done), 64'd1);
    i_mem_ready = 1'b0; i_mem_rvalid = 1'b0;
  endtask
  initial begin
    int nls, nif, nreq, ngnt;
    bit gi, gl;
    step(); step();
    i_rst_n = 1'b1;
    @(negedge clk);
    cmp("reset_busy", 64'(o_busy), 64'd0);
    cmp("reset_mem_req", 64'(o_mem_req), 64'd0);
    // IFU-only read, minimum latency
    step();
    i_if_req = 1'b1; i_if_addr = 64'h8000_0000; i_mem_ready = 1'b1;
    step();
    @(negedge clk);
    cmp("ifu_c1_gnt", 64'(o_if_gnt), 64'd1);
    cmp("ifu_c1_addr", o_mem_addr, 64'h8000_0000);
    step();
    i_if_req = 1'b0; i_mem_rvalid = 1'b1; i_mem_rdata = 64'h13;
    @(negedge clk);
    cmp("ifu_c2_rvalid", 64'(o_if_rvalid), 64'd1);
    cmp("ifu_c2_rdata", o_if_rdata, 64'h13);
    cmp("ifu_c2_ls_rvalid", 64'(o_ls_rvalid), 64'd0);
    step();
    i_mem_rvalid = 1'b0;
    @(negedge clk);
    cmp("ifu_c3_idle", 64'(o_busy), 64'd0);
    // simultaneous IFU and LSU load: LSU first
    step();
    i_if_req = 1'b1; i_if_addr = 64'h100; i_ls_req = 1'b1; i_ls_wen = 1'b0; i_ls_addr = 64'h200;
    step();
    @(negedge clk);
    cmp("both_ls_gnt", 64'(o_ls_gnt), 64'd1);
    cmp("both_ls_addr", o_mem_addr, 64'h200);
    cmp("both_if_wait", 64'(o_if_gnt), 64'd0);
    step();
    i_ls_req = 1'b0; i_mem_rvalid = 1'b1; i_mem_rdata = 64'hAA;
    @(negedge clk);
    cmp("both_ls_rvalid", 64'(o_ls_rvalid), 64'd1);
    cmp("both_if_rvalid", 64'(o_if_rvalid), 64'd0);
    step();
    i_mem_rvalid = 1'b0;
    step();
    @(negedge clk);
    cmp("both_if_gnt", 64'(o_if_gnt), 64'd1);
    cmp("both_if_addr", o_mem_addr, 64'h100);
    step();
    i_if_req = 1'b0;
    drain();
    // LSU store with ready delayed
    i_ls_req = 1'b1; i_ls_wen = 1'b1; i_ls_addr = 64'h40; i_ls_wdata = 64'hDEAD_BEEF; i_ls_wmask = 8'h0F;
    i_mem_ready = 1'b0;
    step();
    nreq = 0; ngnt = 0;
    for (int c = 1; c <= 4; c++) begin
      i_mem_ready = c == 3;
      @(negedge clk);
      nreq += int'(o_mem_req); ngnt += int'(o_ls_gnt);
      if (o_mem_req) begin
        cmp("st_wdata", o_mem_wdata, 64'hDEAD_BEEF);
        cmp("st_wmask", 64'(o_mem_wmask), 64'h0F);
        cmp("st_wen", 64'(o_mem_wen), 64'd1);
      end
      step();
      if (c == 3) i_ls_req = 1'b0;
    end
    cmp("st_req_cycles", 64'(nreq), 64'd3);
    cmp("st_gnt_pulses", 64'(ngnt), 64'd1);
    i_mem_ready = 1'b0; i_mem_rvalid = 1'b1;
    @(negedge clk);
    cmp("st_ack_ls", 64'(o_ls_rvalid), 64'd1);
    cmp("st_ack_if", 64'(o_if_rvalid), 64'd0);
    drain();
    // starvation guard
    i_if_req = 1'b1; i_ls_req = 1'b1; i_ls_wen = 1'b0; i_mem_ready = 1'b1; i_mem_rvalid = 1'b1;
    nls = 0; nif = 0;
    for (int k = 0; k < 40 && nif == 0; k++) begin
      @(negedge clk);
      nls += int'(o_ls_gnt); nif += int'(o_if_gnt);
      step();
    end
    cmp("starve_ls_grants", 64'(nls), 64'd4);
    cmp("starve_if_gnt", 64'(nif), 64'd1);
    gi = 0; gl = 0;
    for (int k = 0; k < 20 && !gi && !gl; k++) begin
      @(negedge clk);
      gi = o_if_gnt; gl = o_ls_gnt;
      step();
    end
    cmp("starve_cleared_ls_wins", 64'(gl), 64'd1);
    i_ls_req = 1'b0;
    drain();
    // reset during LS_RESP, then a late response
    i_ls_req = 1'b1; i_mem_ready = 1'b1;
    step();
    step();
    i_ls_req = 1'b0; i_mem_ready = 1'b0;
    @(negedge clk);
    cmp("rst_pre_busy", 64'(o_busy), 64'd1);
    step();
    i_rst_n = 1'b0;
    #1;
    cmp("rst_async_busy", 64'(o_busy), 64'd0);
    step();
    i_rst_n = 1'b1; i_mem_rvalid = 1'b1; i_mem_rdata = 64'h55;
    @(negedge clk);
    cmp("rst_late_ls_rv", 64'(o_ls_rvalid), 64'd0);
    cmp("rst_late_if_rv", 64'(o_if_rvalid), 64'd0);
    cmp("rst_late_busy", 64'(o_busy), 64'd0);
    // spurious rvalid in IDLE, spurious ready in IF_RESP
    step();
    @(negedge clk);
    cmp("spur_idle_busy", 64'(o_busy), 64'd0);
    step();
    i_mem_rvalid = 1'b0; i_if_req = 1'b1; i_mem_ready = 1'b1;
    step();
    step();
    i_if_req = 1'b0;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      cmp("spur_resp_gnt", 64'(o_if_gnt | o_ls_gnt), 64'd0);
      cmp("spur_resp_busy", 64'(o_busy), 64'd1);
      step();
    end
    drain();
    // randomized traffic
    for (int n = 0; n < 4000; n++) begin
      @(negedge clk);
      gi = o_if_gnt; gl = o_ls_gnt;
      step();
      if (!i_if_req || gi) begin
        i_if_req = ($urandom % 3) == 0;
        i_if_addr = {$urandom, $urandom};
      end
      if (!i_ls_req || gl) begin
        i_ls_req = n < 2000 ? ($urandom % 3) == 0 : ($urandom % 5) != 0;
        i_ls_wen = 1'($urandom);
        i_ls_addr = {$urandom, $urandom};
        i_ls_wdata = {$urandom, $urandom};
        i_ls_wmask = 8'($urandom);
      end
      i_mem_ready = 1'($urandom);
      i_mem_rvalid = 1'($urandom);
      i_mem_rdata = {$urandom, $urandom};
      i_rst_n = ($urandom % 400) != 0;
    end
    i_rst_n = 1'b1;
    drain();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end
endmodule
